// File: rtl/activation_pkg.sv
// Shared constants for the activation stage: mode encodings and mode width.
// Imported by activation_pipe_if, activation_lane and activation_pipe.
package activation_pkg;

  localparam int ACT_MODE_W = 2;

  typedef logic [ACT_MODE_W-1:0] act_mode_t;

  localparam act_mode_t ACT_PASS  = 2'd0;
  localparam act_mode_t ACT_RELU  = 2'd1;
  localparam act_mode_t ACT_LEAKY = 2'd2;
  localparam act_mode_t ACT_CLIP  = 2'd3;

endpackage

// File: rtl/activation_pipe_if.sv
// Stream interface of the activation stage.
//   in_valid/in_ready/in_mode/in_data : upstream beat handshake (mode travels with data)
//   clip_val                          : quasi-static clip ceiling for CLIP mode
//   out_valid/out_ready/out_data      : downstream beat handshake
//   zero_count                        : zero-lane profiling counter
// Modports: slave = the activation stage, master = the environment driving it.
interface activation_pipe_if #(
  parameter int OP_WIDTH  = 16,
  parameter int NUM_LANES = 4
);
  import activation_pkg::*;

  logic                          in_valid;
  logic                          in_ready;
  act_mode_t                     in_mode;
  logic [OP_WIDTH*NUM_LANES-1:0] in_data;
  logic [OP_WIDTH-1:0]           clip_val;
  logic                          out_valid;
  logic                          out_ready;
  logic [OP_WIDTH*NUM_LANES-1:0] out_data;
  logic [31:0]                   zero_count;

  modport slave (
    input  in_valid, in_mode, in_data, clip_val, out_ready,
    output in_ready, out_valid, out_data, zero_count
  );

  modport master (
    output in_valid, in_mode, in_data, clip_val, out_ready,
    input  in_ready, out_valid, out_data, zero_count
  );

endinterface

// File: rtl/activation_lane.sv
// One lane of the activation function (purely combinational).
//   data   : signed lane operand
//   mode   : PASS / RELU / LEAKY / CLIP
//   clip   : signed clip ceiling; negative ceilings behave as 0
//   result : signed lane result
module activation_lane
  import activation_pkg::*;
#(
  parameter int OP_WIDTH    = 16,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic signed [OP_WIDTH-1:0] data,
  input  act_mode_t                  mode,
  input  logic signed [OP_WIDTH-1:0] clip,
  output logic signed [OP_WIDTH-1:0] result
);

  logic signed [OP_WIDTH-1:0] ceil;

  always_comb begin
    ceil   = clip[OP_WIDTH-1] ? '0 : clip;
    result = data;
    case (mode)
      ACT_RELU: begin
        if (data[OP_WIDTH-1]) result = '0;
      end
      ACT_LEAKY: begin
        // Arithmetic shift floors toward -inf, so -1 stays -1 for any shift.
        if (data[OP_WIDTH-1]) result = data >>> LEAKY_SHIFT;
      end
      ACT_CLIP: begin
        if (data[OP_WIDTH-1])  result = '0;
        else if (data > ceil)  result = ceil;
      end
      default: result = data;
    endcase
  end

endmodule

// File: rtl/activation_pipe.sv
// Two-stage activation pipeline for the PE array output path.
// S1 registers the incoming beat and its mode; the lane functions sit between
// S1 and S2; S2 drives the output. Each stage advances when it is empty or the
// next stage can take its beat, giving 1 beat/cycle with no combinational
// in_valid -> out path.
// Ports: clk, reset (synchronous, active-high), bus (activation_pipe_if.slave).
// Build option: define ACTIVATION_ZERO_COUNT_EN to enable the saturating count
// of zero-valued output lanes; otherwise zero_count is tied to 0.
module activation_pipe
  import activation_pkg::*;
#(
  parameter int OP_WIDTH    = 16,
  parameter int NUM_LANES   = 4,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic             clk,
  input  logic             reset,
  activation_pipe_if.slave bus
);

  localparam int DW = OP_WIDTH * NUM_LANES;

  logic          v1, v2;
  logic [DW-1:0] d1, d2, res;
  act_mode_t     m1;
  logic          ready1, ready2;

  assign ready2       = !v2 || bus.out_ready;
  assign ready1       = !v1 || ready2;
  assign bus.in_ready = ready1;
  assign bus.out_valid = v2;
  assign bus.out_data  = d2;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    activation_lane #(
      .OP_WIDTH   (OP_WIDTH),
      .LEAKY_SHIFT(LEAKY_SHIFT)
    ) u_lane (
      .data  (d1[i*OP_WIDTH +: OP_WIDTH]),
      .mode  (m1),
      .clip  (bus.clip_val),
      .result(res[i*OP_WIDTH +: OP_WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      d1 <= '0;
      m1 <= ACT_PASS;
      d2 <= '0;
    end else begin
      if (ready1) begin
        v1 <= bus.in_valid;
        if (bus.in_valid) begin
          d1 <= bus.in_data;
          m1 <= bus.in_mode;
        end
      end
      // clip_val is consumed here, at the S1 -> S2 transfer.
      if (ready2) begin
        v2 <= v1;
        if (v1) d2 <= res;
      end
    end
  end

`ifdef ACTIVATION_ZERO_COUNT_EN
  logic [31:0] zc, zeros;
  logic [32:0] zsum;

  always_comb begin
    zeros = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (d2[i*OP_WIDTH +: OP_WIDTH] == '0) zeros = zeros + 32'd1;
    end
  end

  assign zsum = {1'b0, zc} + {1'b0, zeros};

  always_ff @(posedge clk) begin
    if (reset)                   zc <= '0;
    else if (v2 && bus.out_ready) zc <= zsum[32] ? '1 : zsum[31:0];
  end

  assign bus.zero_count = zc;
`else
  assign bus.zero_count = 32'd0;
`endif

endmodule
